// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage pipelined floating-point multiplier for any
// EXP_W/MAN_W format. There are no Inf/NaN codes, and denormal inputs are
// flushed to zero. Results that overflow saturate to max finite; results
// that underflow are flushed to signed zero.
// Optional build macro FP_MUL_RNE_EN: round-to-nearest-even. If it is not
// defined, the dropped product bits are truncated.
module fp_mul_pipe #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int BIAS  = 7,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_p,
  output logic         out_ovf,
  output logic         out_uf
);

  localparam int EW = EXP_W + 2;
  localparam int MW = MAN_W + 1;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EW-1:0] BIAS_S   = EW'(BIAS);
  localparam logic signed [EW-1:0] EXP_OVF  = EW'(1 << EXP_W);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
`ifdef FP_MUL_RNE_EN
  localparam logic RND_EN = 1'b1;
`else
  localparam logic RND_EN = 1'b0;
`endif

  // stage-1 decode
  logic [EXP_W-1:0]     a_exp, b_exp;
  logic                 a_zero, b_zero;
  logic signed [EW-1:0] exp_sum;
  logic                 adv;

  // stage registers
  logic                 s1_valid, s1_sign, s1_zero;
  logic signed [EW-1:0] s1_exp;
  logic [MW-1:0]        s1_ma, s1_mb;
  logic                 s2_valid, s2_sign, s2_zero;
  logic signed [EW-1:0] s2_exp;
  logic [PW-1:0]        s2_prod;

  // stage-3 normalise/round/saturate
  logic                 norm;
  logic [PW-2:0]        sh;
  logic [MAN_W-1:0]     man_t;
  logic                 guard, sticky, rnd_up;
  logic [MAN_W:0]       man_r;
  logic signed [EW-1:0] exp_f;
  logic [W-1:0]         res_p;
  logic                 res_ovf, res_uf;

  // The whole pipe moves together; a stalled output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign a_exp   = in_a[W-2:MAN_W];
  assign b_exp   = in_b[W-2:MAN_W];
  assign a_zero  = (a_exp == '0);
  assign b_zero  = (b_exp == '0);
  assign exp_sum = {2'b00, a_exp} + {2'b00, b_exp} - BIAS_S;

  // S1: capture sign, zero detect, biased exponent sum and hidden-bit mantissas
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_exp   <= '0;
      s1_ma    <= '0;
      s1_mb    <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_sign  <= in_a[W-1] ^ in_b[W-1];
      s1_zero  <= a_zero || b_zero;
      s1_exp   <= exp_sum;
      s1_ma    <= {1'b1, in_a[MAN_W-1:0]};
      s1_mb    <= {1'b1, in_b[MAN_W-1:0]};
    end
  end

  // S2: full-width mantissa product
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_exp   <= '0;
      s2_prod  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= s1_zero;
      s2_exp   <= s1_exp;
      s2_prod  <= s1_ma * s1_mb;
    end
  end

  // S3 combinational: normalise, round, then saturate or flush on the final exponent
  always_comb begin
    norm    = s2_prod[PW-1];
    // Leading one is dropped; sh holds the stored mantissa bits followed by the bits to be rounded off.
    sh      = norm ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
    man_t   = sh[PW-2 -: MAN_W];
    guard   = sh[PW-2-MAN_W];
    sticky  = |sh[PW-3-MAN_W:0];
    rnd_up  = RND_EN && guard && (sticky || man_t[0]);
    man_r   = {1'b0, man_t} + {{MAN_W{1'b0}}, rnd_up};
    // A rounding carry leaves man_r[MAN_W-1:0] at zero, so only the exponent needs bumping.
    exp_f   = s2_exp + {{(EW-1){1'b0}}, norm} + {{(EW-1){1'b0}}, man_r[MAN_W]};
    res_ovf = 1'b0;
    res_uf  = 1'b0;
    res_p   = {s2_sign, exp_f[EXP_W-1:0], man_r[MAN_W-1:0]};
    if (s2_zero) begin
      res_p = {s2_sign, {(W-1){1'b0}}};
    end else if (exp_f >= EXP_OVF) begin
      res_p   = {s2_sign, {(W-1){1'b1}}};
      res_ovf = 1'b1;
    end else if (exp_f <= EXP_ZERO) begin
      res_p  = {s2_sign, {(W-1){1'b0}}};
      res_uf = 1'b1;
    end
  end

  // S3 register: result and flags; held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_ovf   <= 1'b0;
      out_uf    <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_p   <= res_p;
        out_ovf <= res_ovf;
        out_uf  <= res_uf;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Testbench for fp_mul_pipe (E4M3). It checks every output beat against an
// arithmetic reference model and runs directed, backpressure, reset and
// random traffic.
module tb_fp_mul_pipe;
  localparam int EXP_W = 4;
  localparam int MAN_W = 3;
  localparam int BIAS  = 7;
  localparam int W     = 1 + EXP_W + MAN_W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_p;
  logic         out_ovf;
  logic         out_uf;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int popped = 0;
  bit rand_mode = 1'b0;

  logic [W+1:0] exp_q[$];
  bit           have_prev = 1'b0;
  logic [W+1:0] prev_out;

  fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .BIAS(BIAS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .out_ovf(out_ovf), .out_uf(out_uf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: exact integer product, then pick the leading one, round on the remainder.
  // Returns {ovf, uf, p}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int ea, eb, ma, mb, prod, msb, d, kept, rem, half, e;
    logic s;
    s  = a[W-1] ^ b[W-1];
    ea = int'(a[W-2:MAN_W]);
    eb = int'(b[W-2:MAN_W]);
    if (ea == 0 || eb == 0) return {2'b00, s, {(W-1){1'b0}}};
    ma   = (1 << MAN_W) + int'(a[MAN_W-1:0]);
    mb   = (1 << MAN_W) + int'(b[MAN_W-1:0]);
    prod = ma * mb;
    msb  = 0;
    for (int i = 0; i < 31; i++) if (prod[i]) msb = i;
    e    = ea + eb - BIAS + (msb - 2 * MAN_W);
    d    = msb - MAN_W;
    kept = prod >> d;
    rem  = prod - (kept << d);
    half = 1 << (d - 1);
`ifdef FP_MUL_RNE_EN
    if (rem > half || (rem == half && (kept % 2) == 1)) kept++;
`else
    if (rem < 0 || half < 0) kept = 0;
`endif
    if (kept == (1 << (MAN_W + 1))) begin
      kept = kept >> 1;
      e++;
    end
    if (e >= (1 << EXP_W)) return {2'b10, s, {(W-1){1'b1}}};
    if (e <= 0) return {2'b01, s, {(W-1){1'b0}}};
    return {2'b00, s, e[EXP_W-1:0], kept[MAN_W-1:0]};
  endfunction

  // Compare process: handshake rule, hold-while-stalled, and every delivered beat vs the model queue.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      have_prev = 1'b0;
    end else begin
      chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      if (have_prev) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_hold", {22'd0, out_ovf, out_uf, out_p}, {22'd0, prev_out});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          chk("result", {22'd0, out_ovf, out_uf, out_p}, {22'd0, exp_q.pop_front()});
          popped++;
        end
      end
      have_prev = out_valid && !out_ready;
      prev_out  = {out_ovf, out_uf, out_p};
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b));
        accepted++;
      end
    end
  end

  task automatic step_ready;
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present one pair and hold it until the pipe takes it.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      step_ready();
      n++;
      if (n > 60) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
    step_ready();
  endtask

  task automatic drain;
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic run_one(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ep, input logic eo, input logic eu);
    int lat;
    chk({"model_", nm}, {22'd0, model(a, b)}, {22'd0, eo, eu, ep});
    out_ready = 1'b1;
    send(a, b);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk({"lat_", nm}, lat, 32'd3);
    chk({"p_", nm}, {24'd0, out_p}, {24'd0, ep});
    chk({"ovf_", nm}, {31'd0, out_ovf}, {31'd0, eo});
    chk({"uf_", nm}, {31'd0, out_uf}, {31'd0, eu});
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_p", {24'd0, out_p}, 32'd0);
    chk("rst_flags", {30'd0, out_ovf, out_uf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    run_one("one_x_two",  8'h38, 8'h40, 8'h40, 1'b0, 1'b0);
    run_one("1p5_sq",     8'h3C, 8'h3C, 8'h41, 1'b0, 1'b0);
    run_one("neg",        8'hB8, 8'h40, 8'hC0, 1'b0, 1'b0);
    run_one("zero_a",     8'h00, 8'h7F, 8'h00, 1'b0, 1'b0);
    run_one("negzero",    8'h80, 8'h38, 8'h80, 1'b0, 1'b0);
`ifdef FP_MUL_RNE_EN
    run_one("round_3d",   8'h3D, 8'h3D, 8'h43, 1'b0, 1'b0);
`else
    run_one("round_3d",   8'h3D, 8'h3D, 8'h42, 1'b0, 1'b0);
`endif
    run_one("round_39",   8'h39, 8'h39, 8'h3A, 1'b0, 1'b0);
    run_one("sat_pos",    8'h7F, 8'h7F, 8'h7F, 1'b1, 1'b0);
    run_one("sat_neg",    8'hFF, 8'h7F, 8'hFF, 1'b1, 1'b0);
    run_one("flush",      8'h08, 8'h08, 8'h00, 1'b0, 1'b1);

    // Backpressure: five pairs into a stalled consumer.
    out_ready = 1'b0;
    p0 = popped;
    accepted = 0;
    send(8'h38, 8'h38);
    send(8'h3C, 8'h40);
    send(8'hC4, 8'h3A);
    in_a = 8'h48; in_b = 8'h39; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    chk("bp_accepts", accepted, 32'd3);
    out_ready = 1'b1;
    send(8'h48, 8'h39);
    send(8'h7F, 8'h40);
    drain();
    chk("bp_delivered", popped - p0, 32'd5);

    // Reset with two items in flight.
    out_ready = 1'b1;
    send(8'h40, 8'h40);
    send(8'h44, 8'h44);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_p", {24'd0, out_p}, 32'd0);
    chk("mid_rst_flags", {30'd0, out_ovf, out_uf}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("mid_rst_no_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;

    // Random traffic with random consumer stalls.
    rand_mode = 1'b1;
    p0 = popped;
    for (int t = 0; t < 300; t++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      if ($urandom_range(0, 4) == 0) ra[W-2:MAN_W] = EXP_W'($urandom_range(1, 4));
      if ($urandom_range(0, 4) == 0) rb[W-2:MAN_W] = EXP_W'($urandom_range(11, 15));
      send(ra, rb);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        step_ready();
      end
    end
    rand_mode = 1'b0;
    drain();
    chk("rand_delivered", popped - p0, 32'd300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
